// File: rtl/aximm_test0_mul_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one pipelined unsigned 32x28->60 multiplier between NUM_REQ
// requesters; every product returns on a single id-tagged valid/ready response channel.
module aximm_test0_mul_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_W       = 2,
    parameter int unsigned MUL_STAGES = 1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_din0,
    input  logic [NUM_REQ*28-1:0] req_din1,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [59:0]           rsp_dout,
    output logic                  busy,
    output logic [CNT_W-1:0]      op_count
);

    logic            w_ce;
    logic            w_gnt_found;
    logic [ID_W-1:0] w_gnt_idx;
    logic [ID_W-1:0] w_scan_idx;
    logic            w_xfer;
    logic [31:0]     w_din0;
    logic [27:0]     w_din1;

    logic [ID_W-1:0]  r_rr_ptr;
    logic             r_valid [MUL_STAGES];
    logic [ID_W-1:0]  r_id    [MUL_STAGES];
    logic [59:0]      r_prod  [MUL_STAGES];
    logic [CNT_W-1:0] r_op_count;

    // One enable for multiplier, valid and id pipes keeps them in lockstep.
    assign w_ce   = ~rsp_valid | rsp_ready;
    assign w_xfer = w_gnt_found & w_ce;

    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_scan_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_scan_idx = ID_W'((32'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_gnt_found && req_valid[w_scan_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_scan_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        w_din0    = '0;
        w_din1    = '0;
        if (w_gnt_found) begin
            req_ready[w_gnt_idx] = w_ce;
            w_din0               = req_din0[32*w_gnt_idx +: 32];
            w_din1               = req_din1[28*w_gnt_idx +: 28];
        end
    end

    // Multiplier datapath carries no reset; rsp_dout is qualified by rsp_valid.
    always_ff @(posedge clk) begin
        if (w_ce) begin
            r_prod[0] <= 60'(w_din0) * 60'(w_din1);
            for (int unsigned s = 1; s < MUL_STAGES; s++) begin
                r_prod[s] <= r_prod[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr   <= '0;
            r_op_count <= '0;
            for (int unsigned s = 0; s < MUL_STAGES; s++) begin
                r_valid[s] <= 1'b0;
                r_id[s]    <= '0;
            end
        end else begin
            if (w_ce) begin
                r_valid[0] <= w_xfer;
                r_id[0]    <= w_xfer ? w_gnt_idx : '0;
                for (int unsigned s = 1; s < MUL_STAGES; s++) begin
                    r_valid[s] <= r_valid[s-1];
                    r_id[s]    <= r_id[s-1];
                end
            end
            if (w_xfer) begin
                r_rr_ptr <= (32'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + 1'b1;
            end
            if (rsp_valid && rsp_ready) begin
                r_op_count <= r_op_count + 1'b1;
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned s = 0; s < MUL_STAGES; s++) begin
            busy = busy | r_valid[s];
        end
    end

    assign rsp_valid = r_valid[MUL_STAGES-1];
    assign rsp_id    = r_id[MUL_STAGES-1];
    assign rsp_dout  = r_prod[MUL_STAGES-1];
    assign op_count  = r_op_count;

endmodule

// File: tb/tb_aximm_test0_mul_arbiter.sv
`timescale 1ns/1ps
// Randomized scoreboard bench: a queue-based round-robin model predicts grants and products,
// a separate monitor pops expectations on every response handshake.
module tb_aximm_test0_mul_arbiter;

    localparam int NREQ = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready, d2_req_ready;
    logic [NREQ*32-1:0] req_din0 = '0;
    logic [NREQ*28-1:0] req_din1 = '0;
    logic              rsp_valid, d2_rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [1:0]        rsp_id, d2_rsp_id;
    logic [59:0]       rsp_dout, d2_rsp_dout;
    logic              busy, d2_busy;
    logic [31:0]       op_count;
    logic [3:0]        d2_op_count;

    aximm_test0_mul_arbiter #(
        .NUM_REQ(4), .ID_W(2), .MUL_STAGES(1), .CNT_W(32)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_din0(req_din0), .req_din1(req_din1), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_dout(rsp_dout), .busy(busy),
        .op_count(op_count)
    );

    // Narrow counter instance to exercise op_count wrap.
    aximm_test0_mul_arbiter #(
        .NUM_REQ(4), .ID_W(2), .MUL_STAGES(1), .CNT_W(4)
    ) dut2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(d2_req_ready),
        .req_din0(req_din0), .req_din1(req_din1), .rsp_valid(d2_rsp_valid),
        .rsp_ready(rsp_ready), .rsp_id(d2_rsp_id), .rsp_dout(d2_rsp_dout), .busy(d2_busy),
        .op_count(d2_op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [59:0] prod;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          m_rr = 0;
    int unsigned m_cnt = 0;
    logic [3:0]  rq_v = '0;
    logic [31:0] rq_a [NREQ];
    logic [27:0] rq_b [NREQ];
    int          stream_n = 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]         = rq_v[i];
            req_din0[32*i +: 32] = rq_a[i];
            req_din1[28*i +: 28] = rq_b[i];
        end
    endtask

    // mode 0: random raise, random operands; 1: always raise; 2: stream din0=n, din1=3
    task automatic one_cycle(input logic [3:0] mask, input int ready_pct, input int mode);
        logic [3:0]  exp_ready;
        logic [63:0] p;
        int          gnt;
        bit          ce;
        for (int i = 0; i < NREQ; i++) begin
            if (!mask[i]) begin
                rq_v[i] = 1'b0;
            end else if (!rq_v[i] && (mode != 0 || $urandom_range(0, 99) < 60)) begin
                rq_v[i] = 1'b1;
                if (mode == 2) begin
                    rq_a[i] = 32'(stream_n);
                    rq_b[i] = 28'd3;
                    stream_n++;
                end else begin
                    rq_a[i] = $urandom();
                    rq_b[i] = 28'($urandom());
                end
            end
        end
        drive();
        rsp_ready = ($urandom_range(0, 99) < ready_pct);
        @(negedge clk);
        ce  = (sb.size() == 0) || rsp_ready;
        gnt = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt < 0 && rq_v[(m_rr + k) % NREQ]) gnt = (m_rr + k) % NREQ;
        end
        exp_ready = '0;
        if (ce && gnt >= 0) exp_ready[gnt] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("d2_req_ready", 64'(d2_req_ready), 64'(exp_ready));
        if (exp_ready != '0) begin
            p = 64'(rq_a[gnt]) * 64'(rq_b[gnt]);
            sb.push_back('{gnt, p[59:0]});
            m_rr = (gnt + 1) % NREQ;
            rq_v[gnt] = 1'b0;
        end
        @(posedge clk);
        #1;
        check("rsp_valid", 64'(rsp_valid), 64'(sb.size() != 0));
        check("busy", 64'(busy), 64'(sb.size() != 0));
        check("d2_rsp_valid", 64'(d2_rsp_valid), 64'(sb.size() != 0));
        check("d2_busy", 64'(d2_busy), 64'(sb.size() != 0));
        check("op_count", 64'(op_count), 64'(m_cnt));
        check("op_count_wrap", 64'(d2_op_count), 64'(m_cnt % 16));
    endtask

    // Response monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got id %0d dout %0h expected none",
                             rsp_id, rsp_dout);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", 64'(rsp_id), 64'(e.id));
                    check("rsp_dout", 64'(rsp_dout), 64'(e.prod));
                    check("d2_rsp_id", 64'(d2_rsp_id), 64'(e.id));
                    check("d2_rsp_dout", 64'(d2_rsp_dout), 64'(e.prod));
                    m_cnt++;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            rq_a[i] = '0;
            rq_b[i] = '0;
        end
        drive();
        #3;
        check("reset_req_ready", 64'(req_ready), 64'(0));
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_rsp_id", 64'(rsp_id), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_op_count", 64'(op_count), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;

        // T1: max operands on requester 0
        rq_a[0] = 32'hFFFF_FFFF;
        rq_b[0] = 28'hFFF_FFFF;
        rq_v    = 4'b0001;
        one_cycle(4'b0001, 100, 1);
        check("t1_dout", 64'(rsp_dout), 64'(60'hFFF_FFFE_F000_0001));
        check("t1_id", 64'(rsp_id), 64'(0));
        one_cycle(4'b0000, 100, 1);

        // T5: reset while a product is held under backpressure
        one_cycle(4'b0001, 0, 1);
        reset = 1'b0;
        rq_v  = '0;
        drive();
        #1;
        check("t5_rsp_valid", 64'(rsp_valid), 64'(0));
        check("t5_busy", 64'(busy), 64'(0));
        check("t5_op_count", 64'(op_count), 64'(0));
        check("t5_d2_op_count", 64'(d2_op_count), 64'(0));
        check("t5_req_ready", 64'(req_ready), 64'(0));
        sb.delete();
        m_rr  = 0;
        m_cnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // T2: all requesters busy, grants must rotate 0,1,2,3,...
        repeat (8) one_cycle(4'b1111, 100, 1);
        one_cycle(4'b0000, 100, 1);
        check("t2_op_count", 64'(op_count), 64'(8));

        // T3: stream on requester 2 with a backpressure window
        repeat (2) one_cycle(4'b0100, 100, 2);
        repeat (4) one_cycle(4'b0100, 0, 2);
        repeat (4) one_cycle(4'b0100, 100, 2);
        one_cycle(4'b0000, 100, 2);

        // T4: only requesters 1 and 3, pointer parked at 2
        one_cycle(4'b0010, 100, 1);
        repeat (6) one_cycle(4'b1010, 100, 1);
        one_cycle(4'b0000, 100, 1);

        // Random traffic; also drives the narrow counter through many wraps.
        for (int n = 0; n < 400; n++) begin
            int pct;
            pct = (n % 3 == 0) ? 30 : ((n % 3 == 1) ? 70 : 100);
            one_cycle(4'($urandom()), pct, 0);
        end

        for (int n = 0; n < 10; n++) begin
            if (sb.size() == 0) break;
            one_cycle(4'b0000, 100, 0);
        end
        check("drain_empty", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
